// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with a word FIFO, fixed frame format and per-frame bit divisor.
module uart_tx_frame #(
  parameter int CLK_MHZ    = 50,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            arstn,
  input  logic                            up_valid,
  output logic                            up_ready,
  input  logic [DATA_BITS-1:0]            up_data,
  input  logic [15:0]                     div_i,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] DEF_DIV = 16'(CLK_MHZ * 1000000 / BAUDRATE);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count;
  logic [DATA_BITS-1:0] sh;
  logic [15:0] bit_div, cnt, div_sel;
  logic [3:0] nbit;
  logic par, tick, last, pop, push;
  assign tick = cnt == 16'd0;
  assign last = state == STOP && tick && nbit == 4'(STOP_BITS - 1);
  // Popping in the final stop cycle chains frames with no idle gap.
  assign pop = (state == IDLE || last) && count != '0;
  assign up_ready = count != CW'(FIFO_DEPTH);
  assign push = up_valid && up_ready;
  assign busy = state != IDLE || count != '0;
  assign fifo_count = count;
  assign div_sel = div_i == 16'd0 ? DEF_DIV : div_i;
  always_ff @(posedge clk)
    if (push) mem[wr] <= up_data;
  always_ff @(posedge clk) begin
    if (!arstn) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state <= IDLE;
      tx <= 1'b1;
      sh <= '0;
      bit_div <= 16'd0;
      cnt <= 16'd0;
      nbit <= 4'd0;
      par <= 1'b0;
    end else if (pop) begin
      state <= START;
      tx <= 1'b0;
      sh <= mem[rd];
      bit_div <= div_sel;
      cnt <= div_sel - 16'd1;
      nbit <= 4'd0;
      par <= 1'b0;
    end else if (state != IDLE && tick) begin
      cnt <= bit_div - 16'd1;
      case (state)
        START: begin
          state <= DATA;
          tx <= sh[0];
          nbit <= 4'd0;
        end
        DATA: begin
          par <= par ^ sh[0];
          sh <= sh >> 1;
          nbit <= nbit == 4'(DATA_BITS - 1) ? 4'd0 : nbit + 4'd1;
          if (nbit != 4'(DATA_BITS - 1)) tx <= sh[1];
          else if (PARITY != 0) begin
            state <= PAR;
            tx <= par ^ sh[0] ^ (PARITY == 1);
          end else begin
            state <= STOP;
            tx <= 1'b1;
          end
        end
        PAR: begin
          state <= STOP;
          tx <= 1'b1;
          nbit <= 4'd0;
        end
        STOP: begin
          state <= last ? IDLE : STOP;
          nbit <= nbit + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end else if (state != IDLE) begin
      cnt <= cnt - 16'd1;
    end
  end
endmodule
